qupls4_fc_sched: RTL and testbench

QUPLS4_FC_SCHED -- requirements
Module: qupls4_fc_sched

---
 rtl/qupls4_fc_sched.sv | 103 ++++++++++
 tb/tb_qupls4_fc_sched.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/qupls4_fc_sched.sv
// qupls4_fc_sched: flow-control instruction queue between decode and the
// branch unit. Each decode group carries up to four slots; only slots whose
// flow-control flag is set are enqueued, compacted in program order. The
// branch unit consumes one tag per cycle from the head in strict FIFO order.
// A flush empties the queue in one cycle and suppresses both ports.
module qupls4_fc_sched #(
  parameter int DEPTH = 8,
  parameter int TAGW  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     dec_v,
  input  logic [3:0]               dec_fc,
  input  logic [4*TAGW-1:0]        dec_tag,
  output logic                     dec_rdy,
  output logic                     bu_v,
  output logic [TAGW-1:0]          bu_tag,
  input  logic                     bu_rdy,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   cnt
);

  localparam int PW = $clog2(DEPTH);

  logic [TAGW-1:0] mem [DEPTH];
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [PW-1:0]   head_next;
  logic [PW-1:0]   tail_next;
  logic [PW:0]     cnt_next;
  logic [2:0]      pop;
  logic [PW-1:0]   wr_idx [4];
  logic            enq;
  logic            deq;

  // Room for a full four-slot group is judged from the registered count only,
  // so an entry freed this cycle is only visible to decode next cycle.
  assign dec_rdy = (cnt <= (PW+1)'(DEPTH - 4));

  // Head of the queue is presented straight from storage; no enqueue bypass.
  assign bu_v   = (cnt != '0);
  assign bu_tag = mem[head];

  assign enq = dec_v & dec_rdy & ~flush;
  assign deq = bu_v & bu_rdy & ~flush;

  // Compaction: each flagged slot lands at tail plus the number of flagged
  // slots older than it; pop ends up as the total flagged count.
  always_comb begin
    // NOTE: every always_comb output gets a default before any conditional
    // logic so no path leaves it unassigned and a latch is never inferred.
    pop = 3'd0;
    for (int i = 0; i < 4; i++) begin
      wr_idx[i] = tail + PW'(pop);
      pop       = pop + {2'b00, dec_fc[i]};
    end
  end

  // Next pointer and occupancy values; flush overrides every other update.
  always_comb begin
    head_next = head;
    tail_next = tail;
    cnt_next  = cnt;
    if (flush) begin
      head_next = '0;
      tail_next = '0;
      cnt_next  = '0;
    end else begin
      if (enq) tail_next = tail + PW'(pop);
      if (deq) head_next = head + PW'(1);
      cnt_next = cnt
               + (enq ? (PW+1)'(pop) : (PW+1)'(0))
               - (PW+1)'(deq);
    end
  end

  // Pointer and occupancy registers, cleared asynchronously by reset.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      head <= head_next;
      tail <= tail_next;
      cnt  <= cnt_next;
    end
  end

  // Tag storage writes for the flagged slots of an accepted group.
  always_ff @(posedge clk) begin
    // NOTE: storage has no reset; cnt gates every read, so stale contents are
    // never observed and the array can map onto plain RAM/flop cells.
    if (enq) begin
      for (int i = 0; i < 4; i++) begin
        if (dec_fc[i]) mem[wr_idx[i]] <= dec_tag[i*TAGW +: TAGW];
      end
    end
  end

endmodule

// File: tb/tb_qupls4_fc_sched.sv
// tb_qupls4_fc_sched: directed scenarios plus randomized traffic, each cycle
// compared against a queue-based reference model of the scheduler.
module tb_qupls4_fc_sched;

  localparam int DEPTH = 8;
  localparam int TAGW  = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              dec_v;
  logic [3:0]        dec_fc;
  logic [4*TAGW-1:0] dec_tag;
  logic              dec_rdy;
  logic              bu_v;
  logic [TAGW-1:0]   bu_tag;
  logic              bu_rdy;
  logic              flush;
  logic [3:0]        cnt;

  int total = 0;
  int bad   = 0;

  logic [TAGW-1:0] model_q [$];
  logic [TAGW-1:0] issued_q [$];

  qupls4_fc_sched #(.DEPTH(DEPTH), .TAGW(TAGW)) dut (
    .clk(clk), .rst(rst), .dec_v(dec_v), .dec_fc(dec_fc), .dec_tag(dec_tag),
    .dec_rdy(dec_rdy), .bu_v(bu_v), .bu_tag(bu_tag), .bu_rdy(bu_rdy),
    .flush(flush), .cnt(cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] pack(input logic [7:0] t3, input logic [7:0] t2,
                                       input logic [7:0] t1, input logic [7:0] t0);
    return {t3, t2, t1, t0};
  endfunction

  // One cycle: drive at negedge, compare outputs with the model, update the
  // model from the rules, then let the edge happen.
  task automatic step(input logic v, input logic [3:0] fc, input logic [31:0] tags,
                      input logic br, input logic fl);
    int  sz;
    bit  accept;
    @(negedge clk);
    dec_v = v; dec_fc = fc; dec_tag = tags; bu_rdy = br; flush = fl;
    #1;
    sz = model_q.size();
    check("cnt", 32'(cnt), 32'(sz));
    check("dec_rdy", 32'(dec_rdy), 32'((DEPTH - sz) >= 4));
    check("bu_v", 32'(bu_v), 32'(sz != 0));
    if (sz != 0) check("bu_tag", 32'(bu_tag), 32'(model_q[0]));
    if (bu_v && br && !fl) issued_q.push_back(bu_tag);
    if (fl) begin
      model_q.delete();
    end else begin
      accept = v && ((DEPTH - sz) >= 4);
      if (sz != 0 && br) void'(model_q.pop_front());
      if (accept)
        for (int i = 0; i < 4; i++)
          if (fc[i]) model_q.push_back(tags[i*8 +: 8]);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    step(1'b0, 4'b0000, 32'h0, 1'b0, 1'b1);
  endtask

  initial begin
    rst = 1'b1; dec_v = 1'b0; dec_fc = '0; dec_tag = '0; bu_rdy = 1'b0; flush = 1'b0;
    #12;
    check("rst_cnt", 32'(cnt), 0);
    check("rst_bu_v", 32'(bu_v), 0);
    check("rst_dec_rdy", 32'(dec_rdy), 1);
    @(negedge clk);
    rst = 1'b0;

    // Compacted enqueue of slots 1 and 3.
    step(1'b1, 4'b1010, pack(8'h13, 8'h12, 8'h11, 8'h10), 1'b0, 1'b0);
    check("fc1010_cnt", 32'(cnt), 2);
    check("fc1010_bu_v", 32'(bu_v), 1);
    check("fc1010_head", 32'(bu_tag), 32'h11);
    step(1'b0, 4'b0000, 32'h0, 1'b1, 1'b0);
    check("fc1010_second", 32'(bu_tag), 32'h13);
    clear_q();

    // Fill to full, third group ignored.
    step(1'b1, 4'b1111, pack(8'h03, 8'h02, 8'h01, 8'h00), 1'b0, 1'b0);
    check("fill1_cnt", 32'(cnt), 4);
    step(1'b1, 4'b1111, pack(8'h07, 8'h06, 8'h05, 8'h04), 1'b0, 1'b0);
    check("fill2_cnt", 32'(cnt), 8);
    check("fill2_rdy", 32'(dec_rdy), 0);
    step(1'b1, 4'b1111, pack(8'h0b, 8'h0a, 8'h09, 8'h08), 1'b0, 1'b0);
    check("fill3_cnt", 32'(cnt), 8);
    check("fill3_head", 32'(bu_tag), 32'h00);
    clear_q();

    // Simultaneous enqueue of three and dequeue of one.
    step(1'b1, 4'b1111, pack(8'h23, 8'h22, 8'h21, 8'h20), 1'b0, 1'b0);
    check("simul_head", 32'(bu_tag), 32'h20);
    step(1'b1, 4'b0111, pack(8'h27, 8'h26, 8'h25, 8'h24), 1'b1, 1'b0);
    check("simul_cnt", 32'(cnt), 6);
    check("simul_next", 32'(bu_tag), 32'h21);
    clear_q();

    // Pointer wrap with 1-in/1-out traffic.
    issued_q.delete();
    step(1'b1, 4'b0001, pack(8'h0, 8'h0, 8'h0, 8'd100), 1'b0, 1'b0);
    for (int k = 0; k < 20; k++)
      step(1'b1, 4'b0001, pack(8'h0, 8'h0, 8'h0, 8'(101 + k)), 1'b1, 1'b0);
    check("wrap_count", 32'(issued_q.size()), 20);
    for (int k = 0; k < 20 && k < issued_q.size(); k++)
      check("wrap_order", 32'(issued_q[k]), 32'(100 + k));
    clear_q();

    // Flush dominates enqueue and dequeue.
    step(1'b1, 4'b1111, pack(8'h33, 8'h32, 8'h31, 8'h30), 1'b0, 1'b0);
    step(1'b1, 4'b0001, pack(8'h0, 8'h0, 8'h0, 8'h34), 1'b0, 1'b0);
    check("pre_flush_cnt", 32'(cnt), 5);
    issued_q.delete();
    step(1'b1, 4'b1111, pack(8'h3b, 8'h3a, 8'h39, 8'h38), 1'b1, 1'b1);
    check("flush_cnt", 32'(cnt), 0);
    check("flush_bu_v", 32'(bu_v), 0);
    check("flush_rdy", 32'(dec_rdy), 1);
    check("flush_issued", 32'(issued_q.size()), 0);

    // Asynchronous reset between edges.
    step(1'b1, 4'b0111, pack(8'h0, 8'h42, 8'h41, 8'h40), 1'b0, 1'b0);
    check("pre_rst_cnt", 32'(cnt), 3);
    dec_v = 1'b0; dec_fc = '0;
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_cnt", 32'(cnt), 0);
    check("async_rst_bu_v", 32'(bu_v), 0);
    check("async_rst_rdy", 32'(dec_rdy), 1);
    model_q.delete();
    @(negedge clk);
    rst = 1'b0;

    // Randomized traffic against the model.
    for (int n = 0; n < 500; n++) begin
      step(1'($urandom_range(0, 3) != 0), 4'($urandom), $urandom,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 24) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
